// File: rtl/fork_scheduler_if.sv
// Fork scheduler bus: per-philosopher event FIFO heads in, pop/grant
// strobes and fork/eating/waiting status out. master = scheduler side.
interface fork_scheduler_if #(
  parameter int N_PHILO = 4
);
  logic [N_PHILO-1:0] evt_empty;
  logic [N_PHILO-1:0] evt_data;
  logic [N_PHILO-1:0] evt_ack;
  logic [N_PHILO-1:0] may_eat;
  logic [N_PHILO-1:0] eating;
  logic [N_PHILO-1:0] waiting;
  logic [N_PHILO-1:0] fork_taken;
  logic               busy;
  logic               err;

  modport master (
    input  evt_empty, evt_data,
    output evt_ack, may_eat, eating, waiting,
    output fork_taken, busy, err
  );

  modport slave (
    output evt_empty, evt_data,
    input  evt_ack, may_eat, eating, waiting,
    input  fork_taken, busy, err
  );
endinterface

// File: rtl/fork_scheduler.sv
// Round-robin fork arbiter: pops one HUNGRY/DONE event per turn, then
// scans all philosophers once for grants. Ports: clk, reset, bus (master).
module fork_scheduler #(
  parameter int N_PHILO = 4,
  parameter int PTR_W   = 2
) (
  input logic               clk,
  input logic               reset,
  fork_scheduler_if.master  bus
);

  typedef enum logic [1:0] {IDLE, POP, GRANT} state_t;

  localparam logic [PTR_W-1:0] LAST = PTR_W'(N_PHILO - 1);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ev_ptr_q, ev_ptr_d;
  logic [PTR_W-1:0]   gr_ptr_q, gr_ptr_d;
  logic [PTR_W-1:0]   sel_q, sel_d;
  logic [PTR_W-1:0]   j_q, j_d;
  logic [PTR_W-1:0]   cnt_q, cnt_d;
  logic               kind_q, kind_d;
  logic [N_PHILO-1:0] eat_q, eat_d;
  logic [N_PHILO-1:0] wait_q, wait_d;
  logic [N_PHILO-1:0] fork_q, fork_d;
  logic [N_PHILO-1:0] ack_q, ack_d;
  logic [N_PHILO-1:0] may_q, may_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic               found;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   idx;
  logic [PTR_W-1:0]   jn;
  int                 t;

  // Modulo-N increment: wraps at N_PHILO-1, not at 2^PTR_W-1.
  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    state_d  = state_q;
    ev_ptr_d = ev_ptr_q;
    gr_ptr_d = gr_ptr_q;
    sel_d    = sel_q;
    kind_d   = kind_q;
    j_d      = j_q;
    cnt_d    = cnt_q;
    eat_d    = eat_q;
    wait_d   = wait_q;
    fork_d   = fork_q;
    err_d    = err_q;
    ack_d    = '0;
    may_d    = '0;
    found    = 1'b0;
    pick     = '0;
    idx      = '0;
    t        = 0;
    jn       = inc(j_q);

    // First non-empty FIFO at or after ev_ptr, with wrap.
    for (int k = 0; k < N_PHILO; k++) begin
      t = int'(ev_ptr_q) + k;
      if (t >= N_PHILO) t = t - N_PHILO;
      idx = PTR_W'(t);
      if (!found && !bus.evt_empty[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (found) begin
          sel_d      = pick;
          kind_d     = bus.evt_data[pick];
          ev_ptr_d   = inc(pick);
          ack_d[pick] = 1'b1;
          state_d    = POP;
        end
      end
      POP: begin
        if (!kind_q && !wait_q[sel_q] && !eat_q[sel_q]) begin
          wait_d[sel_q] = 1'b1;
        end else if (kind_q && eat_q[sel_q]) begin
          eat_d[sel_q]       = 1'b0;
          fork_d[sel_q]      = 1'b0;
          fork_d[inc(sel_q)] = 1'b0;
        end else begin
          err_d = 1'b1;
        end
        j_d     = gr_ptr_q;
        cnt_d   = '0;
        state_d = GRANT;
      end
      GRANT: begin
        // Registered state only; a grant here is seen by the next check.
        if (wait_q[j_q] && !fork_q[j_q] && !fork_q[jn]) begin
          wait_d[j_q] = 1'b0;
          eat_d[j_q]  = 1'b1;
          fork_d[j_q] = 1'b1;
          fork_d[jn]  = 1'b1;
          may_d[j_q]  = 1'b1;
          gr_ptr_d    = jn;
        end
        j_d   = jn;
        cnt_d = cnt_q + PTR_W'(1);
        if (cnt_q == LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ev_ptr_q <= '0;
      gr_ptr_q <= '0;
      sel_q    <= '0;
      kind_q   <= 1'b0;
      j_q      <= '0;
      cnt_q    <= '0;
      eat_q    <= '0;
      wait_q   <= '0;
      fork_q   <= '0;
      ack_q    <= '0;
      may_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ev_ptr_q <= ev_ptr_d;
      gr_ptr_q <= gr_ptr_d;
      sel_q    <= sel_d;
      kind_q   <= kind_d;
      j_q      <= j_d;
      cnt_q    <= cnt_d;
      eat_q    <= eat_d;
      wait_q   <= wait_d;
      fork_q   <= fork_d;
      ack_q    <= ack_d;
      may_q    <= may_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.evt_ack    = ack_q;
  assign bus.may_eat    = may_q;
  assign bus.eating     = eat_q;
  assign bus.waiting    = wait_q;
  assign bus.fork_taken = fork_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_fork_scheduler.sv
// Directed bench for fork_scheduler (N_PHILO=4): reset, grants,
// neighbour conflict, round-robin pops, protocol errors, async reset.
module tb_fork_scheduler;

  logic clk;
  logic reset;
  int   passed;
  int   total;
  logic [3:0] acc;

  fork_scheduler_if #(.N_PHILO(4)) bus ();

  fork_scheduler #(.N_PHILO(4), .PTR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 30) begin
      step();
      n++;
    end
    check(tag, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic inv(input string tag);
    logic [3:0] e;
    logic [3:0] f;
    e = bus.eating;
    f = e | {e[2:0], e[3]};
    check({tag, "_fork"}, {28'd0, bus.fork_taken}, {28'd0, f});
    check({tag, "_adj"}, {28'd0, e & {e[0], e[3:1]}}, 32'd0);
    check({tag, "_we"}, {28'd0, bus.waiting & e}, 32'd0);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    acc    = '0;
    reset  = 1'b1;
    bus.evt_empty = 4'b1111;
    bus.evt_data  = 4'b0000;

    // Reset held while events are pending.
    #2;
    bus.evt_empty = 4'b0000;
    repeat (3) begin
      step();
      acc |= bus.evt_ack;
    end
    check("rst_ack", {28'd0, acc}, 32'd0);
    check("rst_outs", {16'd0, bus.may_eat, bus.eating,
          bus.waiting, bus.fork_taken}, 32'd0);
    check("rst_flags", {30'd0, bus.busy, bus.err}, 32'd0);
    bus.evt_empty = 4'b1111;
    reset = 1'b0;
    step();
    check("rel_busy", {31'd0, bus.busy}, 32'd0);

    // Single grant to philosopher 2.
    bus.evt_empty = 4'b1011;
    bus.evt_data  = 4'b0000;
    step();
    check("sg_ack", {28'd0, bus.evt_ack}, 32'h4);
    check("sg_busy", {31'd0, bus.busy}, 32'd1);
    bus.evt_empty = 4'b1111;
    bus.evt_data  = 4'b0100;
    step();
    check("sg_wait", {28'd0, bus.waiting}, 32'h4);
    acc = bus.may_eat;
    step();
    acc |= bus.may_eat;
    step();
    acc |= bus.may_eat;
    check("sg_early", {28'd0, acc}, 32'd0);
    step();
    check("sg_may", {28'd0, bus.may_eat}, 32'h4);
    check("sg_eat", {28'd0, bus.eating}, 32'h4);
    check("sg_fork", {28'd0, bus.fork_taken}, 32'hc);
    check("sg_wait0", {28'd0, bus.waiting}, 32'd0);
    step();
    check("sg_idle", {31'd0, bus.busy}, 32'd0);
    check("sg_may0", {28'd0, bus.may_eat}, 32'd0);
    bus.evt_data = 4'b0000;

    // Neighbour conflict: 3 hungry while 2 eats.
    bus.evt_empty = 4'b0111;
    step();
    check("nc_ack", {28'd0, bus.evt_ack}, 32'h8);
    bus.evt_empty = 4'b1111;
    step();
    check("nc_wait", {28'd0, bus.waiting}, 32'h8);
    acc = bus.may_eat;
    repeat (4) begin
      step();
      acc |= bus.may_eat;
    end
    check("nc_nomay", {28'd0, acc}, 32'd0);
    check("nc_idle", {31'd0, bus.busy}, 32'd0);
    check("nc_eat", {28'd0, bus.eating}, 32'h4);
    bus.evt_empty = 4'b1011;
    bus.evt_data  = 4'b0100;
    step();
    check("nc_ack2", {28'd0, bus.evt_ack}, 32'h4);
    bus.evt_empty = 4'b1111;
    bus.evt_data  = 4'b0000;
    step();
    step();
    check("nc_may", {28'd0, bus.may_eat}, 32'h8);
    check("nc_eat2", {28'd0, bus.eating}, 32'h8);
    check("nc_fork", {28'd0, bus.fork_taken}, 32'h9);
    check("nc_wait0", {28'd0, bus.waiting}, 32'd0);
    wait_idle("nc_done");
    inv("nc_inv");

    // All four hungry at once from reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("sim_clr", {28'd0, bus.eating}, 32'd0);
    bus.evt_empty = 4'b0000;
    for (int a = 0; a < 4; a++) begin
      if (a > 0) begin
        acc = '0;
        repeat (5) begin
          step();
          acc |= bus.evt_ack;
        end
        check("sim_gap", {28'd0, acc}, 32'd0);
      end
      step();
      check("sim_ack", {28'd0, bus.evt_ack}, {28'd0, 4'b0001 << a});
      bus.evt_empty[a] = 1'b1;
    end
    wait_idle("sim_done");
    check("sim_eat", {28'd0, bus.eating}, 32'h5);
    check("sim_wait", {28'd0, bus.waiting}, 32'ha);
    check("sim_fork", {28'd0, bus.fork_taken}, 32'hf);
    check("sim_err", {31'd0, bus.err}, 32'd0);
    inv("sim_inv");

    // DONE from a non-eating philosopher.
    bus.evt_empty = 4'b1101;
    bus.evt_data  = 4'b0010;
    step();
    check("pe_ack", {28'd0, bus.evt_ack}, 32'h2);
    bus.evt_empty = 4'b1111;
    bus.evt_data  = 4'b0000;
    wait_idle("pe_done");
    check("pe_err", {31'd0, bus.err}, 32'd1);
    check("pe_eat", {28'd0, bus.eating}, 32'h5);
    check("pe_fork", {28'd0, bus.fork_taken}, 32'hf);
    check("pe_wait", {28'd0, bus.waiting}, 32'ha);

    // HUNGRY from an already waiting philosopher.
    bus.evt_empty = 4'b0111;
    step();
    check("pw_ack", {28'd0, bus.evt_ack}, 32'h8);
    bus.evt_empty = 4'b1111;
    wait_idle("pw_done");
    check("pw_err", {31'd0, bus.err}, 32'd1);
    check("pw_eat", {28'd0, bus.eating}, 32'h5);
    check("pw_wait", {28'd0, bus.waiting}, 32'ha);

    // Reset in the second GRANT cycle.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rg_err0", {31'd0, bus.err}, 32'd0);
    bus.evt_empty = 4'b1110;
    step();
    check("rg_ack", {28'd0, bus.evt_ack}, 32'h1);
    bus.evt_empty = 4'b1111;
    step();
    step();
    check("rg_may", {28'd0, bus.may_eat}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("rg_outs", {16'd0, bus.may_eat, bus.eating,
          bus.waiting, bus.fork_taken}, 32'd0);
    check("rg_flags", {26'd0, bus.evt_ack, bus.busy, bus.err}, 32'd0);
    bus.evt_empty = 4'b0000;
    acc = '0;
    repeat (2) begin
      step();
      acc |= bus.evt_ack;
    end
    check("rg_hold", {28'd0, acc}, 32'd0);
    bus.evt_empty = 4'b1111;
    reset = 1'b0;
    step();
    check("rg_busy", {31'd0, bus.busy}, 32'd0);
    bus.evt_empty = 4'b1110;
    step();
    check("rg_ack2", {28'd0, bus.evt_ack}, 32'h1);
    bus.evt_empty = 4'b1111;
    step();
    step();
    check("rg_may2", {28'd0, bus.may_eat}, 32'h1);
    wait_idle("rg_done");
    check("rg_eat", {28'd0, bus.eating}, 32'h1);
    check("rg_fork", {28'd0, bus.fork_taken}, 32'h3);
    inv("rg_inv");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fork_scheduler.md
# fork_scheduler

- Round-robin fork arbiter for the dining-philosophers design.
- Drains one pending event per turn from the N_PHILO per-philosopher event FIFOs, each event being HUNGRY or DONE.
- Keeps the fork and eating state, and grants eating rights with a fair, scanned grant pointer.
- Sits between the philo array (may_eat/hungry/FIFO ports) and the LED/debug logic, on the same clock as the philosophers.

## Interface
- N_PHILO, 4, number of philosophers and forks (>= 2); philosopher n uses fork n and fork (n+1)%N_PHILO.
- PTR_W, 2, width of event/grant pointers and scan counter; must be >= clog2(N_PHILO), minimum 1.
- clk  in  1  sole clock; all state changes on posedge clk.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- evt_empty  in  N_PHILO  per-FIFO empty flag (first-word-fall-through).
- evt_data  in  N_PHILO  head entry of each FIFO, valid while its evt_empty is 0: 0 = HUNGRY, 1 = DONE.
- evt_ack  out  N_PHILO  pop strobe; one-hot one-cycle pulse.
- may_eat  out  N_PHILO  grant strobe; one-cycle pulse per grant.
- eating  out  N_PHILO  philosopher currently holds both forks.
- waiting  out  N_PHILO  HUNGRY received, not yet granted.
- fork_taken  out  N_PHILO  fork n in use.
- busy  out  1  FSM not in IDLE.
- err  out  1  sticky protocol-error flag.

## Operation
- All outputs registered. Reset value of every output, ev_ptr, gr_ptr and scan count is 0; state resets to IDLE.
- FSM states: IDLE, POP, GRANT.
- IDLE:
  - Select the first i with evt_empty[i]=0, searching from ev_ptr upward with wrap.
  - If found: latch sel=i and kind=evt_data[i], set ev_ptr=(i+1)%N_PHILO, then go to POP.
  - Else stay in IDLE.
- POP (one cycle):
  - evt_ack[sel]=1 this cycle.
  - Apply the event:
    - HUNGRY with waiting[sel]=0 and eating[sel]=0: set waiting[sel].
    - DONE with eating[sel]=1: clear eating[sel] and both of sel's forks.
    - Any other combination: set err; no other state change.
  - Set scan index j=gr_ptr and count=0, then go to GRANT.
- GRANT (exactly N_PHILO cycles, one philosopher checked per cycle):
  - Grant j when waiting[j]=1 and both fork j and fork (j+1)%N_PHILO are free, as seen in this cycle's registered state.
  - On grant: set both forks taken, eating[j]=1, waiting[j]=0, may_eat[j]=1 for the next cycle only, and gr_ptr=(j+1)%N_PHILO.
  - Each cycle advance j=(j+1)%N_PHILO. After the N_PHILO-th check, go to IDLE.
- Multiple grants per scan are allowed. Fork updates from an earlier check in the same scan are visible to later checks.
- Invariants checked by the bench:
  - fork_taken equals the OR over n of eating[n] on forks n and (n+1)%N_PHILO.
  - Adjacent philosophers are never both eating.
  - waiting & eating == 0.
- err clears only on reset.

## Timing
- Event detected in IDLE at cycle T.
- evt_ack pulse at T+1. The FIFO holds its head until the ack, and the latched data is used even if evt_data changes after T.
- GRANT checks run at cycles T+2 .. T+1+N_PHILO.
- A grant decided at cycle c produces the may_eat pulse at c+1: best case T+3, worst case T+2+N_PHILO.
- IDLE is re-entered at T+2+N_PHILO. Minimum spacing between consecutive acks is N_PHILO+2 cycles.
- Simultaneous non-empty FIFOs are served round-robin from ev_ptr, so no FIFO waits more than N_PHILO turns.
- Reset asserted mid-operation clears all outputs asynchronously in the same cycle, including any in-flight evt_ack or may_eat pulse. After deassertion the FSM restarts in IDLE with both pointers at 0.
- Pointer arithmetic is modulo N_PHILO. This holds for non-power-of-two N_PHILO: wrap occurs at N_PHILO-1, not at 2^PTR_W-1.

## Test plan
- Reset: hold reset, drive events -> all outputs 0, no evt_ack; release reset -> busy=0.
- Single grant (N=4): evt_data[2]=0, evt_empty[2]=0 at T -> evt_ack=0100 at T+1; check order 0,1,2 at T+2..T+4; may_eat=0100 at T+5; eating=0100, fork_taken=1100, gr_ptr=3.
- Neighbor conflict: philosopher 2 eating, philosopher 3 HUNGRY -> waiting=1000, no may_eat. Then philosopher 2 DONE -> may_eat[3] within 4 cycles of the ack; eating=1000, fork_taken=1001.
- Simultaneous: all four HUNGRY at one cycle from reset -> acks 0,1,2,3 spaced 6 cycles apart; final eating=0101, waiting=1010, fork_taken=1111, err=0.
- Protocol error: DONE from philosopher 1 while not eating -> evt_ack[1] pulses, err=1 and stays 1, eating/fork_taken unchanged. HUNGRY from a waiting philosopher -> same result.
- Reset mid-GRANT: assert reset on the 2nd GRANT cycle -> all outputs 0 immediately. A new HUNGRY from philosopher 0 after release -> may_eat=0001 at T+3.
